// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
//  Shared AES key-schedule definitions used by the forward and inverse
//  schedules: the S-box and round-constant tables, word/key typedefs and
//  the key-schedule state enum.
// ---------------------------------------------------------------------------
package aes_pkg;

   typedef logic [31:0]  word_t;
   typedef logic [127:0] key_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXPAND = 2'd1,
      DONE   = 2'd2
   } ks_state_e;

   localparam int NUM_SLOTS = 11;

   localparam logic [7:0] SBOX [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   localparam logic [7:0] RCON [0:9] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

endpackage : aes_pkg

// File: rtl/aes_subword.sv
// ---------------------------------------------------------------------------
// aes_subword
//  Combinational AES SubWord: applies the S-box to each byte of a word.
//  Shared between the forward and inverse key schedules.
//  Ports:
//   word_i  in   32  input word, byte 0 in [31:24]
//   word_o  out  32  S-box substituted word, same byte order
// ---------------------------------------------------------------------------
module aes_subword
   import aes_pkg::*;
(
   input  word_t word_i,
   output word_t word_o
);

   assign word_o = {SBOX[word_i[31:24]], SBOX[word_i[23:16]],
                    SBOX[word_i[15:8]],  SBOX[word_i[7:0]]};

endmodule : aes_subword

// File: rtl/inv_key_schedule.sv
// ---------------------------------------------------------------------------
// inv_key_schedule
//  Decryption-side AES-128 key schedule. Starting from the round-10 key it
//  walks the expansion backwards one round per clock, storing all 11 round
//  keys so the inverse cipher can read them in any order by index.
//  Optional build macro: INV_KS_ORIG_CHECK_EN adds the Match output, which
//  compares the recovered round-0 key against the ORIG_KEY parameter.
//  Ports:
//   Clk      in   1    clock, rising edge
//   Rst      in   1    synchronous active-high reset
//   En       in   1    start pulse; LastKey sampled on the start edge
//   LastKey  in   128  round-10 key, byte 0 in [127:120]
//   SelKey   in   4    round-key index 0..10; 11..15 read round 0
//   Key      out  128  registered round key for SelKey (1-cycle latency)
//   Ry       out  1    all 11 round keys valid
//   Match    out  1    (INV_KS_ORIG_CHECK_EN only) round 0 == ORIG_KEY
// ---------------------------------------------------------------------------
module inv_key_schedule
   import aes_pkg::*;
`ifdef INV_KS_ORIG_CHECK_EN
#(
   parameter key_t ORIG_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c
)
`endif
(
   input  logic         Clk,
   input  logic         Rst,
   input  logic         En,
   input  logic [127:0] LastKey,
   input  logic [3:0]   SelKey,
   output logic [127:0] Key,
   output logic         Ry
`ifdef INV_KS_ORIG_CHECK_EN
  ,output logic         Match
`endif
);

   ks_state_e   state_q, state_d;
   logic [3:0]  rnd_q, rnd_d;
   logic        ry_q, ry_d;
   key_t        key_q;
   key_t        slot_q [0:NUM_SLOTS-1];

   logic        wr_en;
   logic [3:0]  wr_idx;
   key_t        wr_data;
   logic [3:0]  sel_idx;

   // Backward round step on the slot currently pointed at by rnd.
   key_t        cur_key;
   word_t       w0, w1, w2, w3;
   word_t       p0, p1, p2, p3;
   word_t       sub_rot;
   logic [3:0]  rcon_idx;
   key_t        step_key;

   assign cur_key  = slot_q[rnd_q];
   assign {w0, w1, w2, w3} = cur_key;
   assign p3       = w3 ^ w2;
   assign p2       = w2 ^ w1;
   assign p1       = w1 ^ w0;
   assign rcon_idx = rnd_q - 4'd1;

   // p3 is the recovered previous-round w3, so it feeds RotWord/SubWord
   // exactly as the forward schedule's last word does.
   aes_subword u_subword (
      .word_i ({p3[23:0], p3[31:24]}),
      .word_o (sub_rot)
   );

   assign p0       = w0 ^ sub_rot ^ {RCON[rcon_idx], 24'h0};
   assign step_key = {p0, p1, p2, p3};

   // Indices past the last round alias to round 0.
   assign sel_idx  = (SelKey > 4'd10) ? 4'd0 : SelKey;

`ifdef INV_KS_ORIG_CHECK_EN
   logic match_q, match_d;
`endif

   always_comb begin
      // NOTE: every signal driven here gets a default first so no path can
      // leave it unassigned and infer a latch.
      state_d = state_q;
      rnd_d   = rnd_q;
      ry_d    = ry_q;
      wr_en   = 1'b0;
      wr_idx  = rcon_idx;
      wr_data = step_key;
`ifdef INV_KS_ORIG_CHECK_EN
      match_d = match_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (En) begin
               wr_en   = 1'b1;
               wr_idx  = 4'd10;
               wr_data = LastKey;
               rnd_d   = 4'd10;
               ry_d    = 1'b0;
               state_d = EXPAND;
`ifdef INV_KS_ORIG_CHECK_EN
               match_d = 1'b0;
`endif
            end
         end
         EXPAND: begin
            // En is deliberately ignored here; LastKey is not resampled.
            wr_en = 1'b1;
            rnd_d = rnd_q - 4'd1;
            if (rnd_q == 4'd1) begin
               state_d = DONE;
               ry_d    = 1'b1;
`ifdef INV_KS_ORIG_CHECK_EN
               match_d = (step_key == ORIG_KEY);
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples pre-edge values regardless of statement order.
      if (Rst) begin
         state_q <= IDLE;
         rnd_q   <= 4'd0;
         ry_q    <= 1'b0;
         key_q   <= '0;
         // NOTE: the round-key storage is reset too, because a read of an
         // unwritten slot must return zero after reset rather than X.
         for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_q[i] <= '0;
         end
`ifdef INV_KS_ORIG_CHECK_EN
         match_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         rnd_q   <= rnd_d;
         ry_q    <= ry_d;
         key_q   <= slot_q[sel_idx];
         if (wr_en) begin
            slot_q[wr_idx] <= wr_data;
         end
`ifdef INV_KS_ORIG_CHECK_EN
         match_q <= match_d;
`endif
      end
   end

   assign Key = key_q;
   assign Ry  = ry_q;
`ifdef INV_KS_ORIG_CHECK_EN
   assign Match = match_q;
`endif

endmodule : inv_key_schedule

// File: tb/tb_inv_key_schedule.sv
// ---------------------------------------------------------------------------
// tb_inv_key_schedule
//  Self-checking bench for inv_key_schedule. The reference model derives the
//  S-box from GF(2^8) inversion plus the affine map, and unwinds the forward
//  word recurrence w[i] = w[i-4] ^ temp(w[i-1]) from word 43 down to word 0.
//  Build macro INV_KS_ORIG_CHECK_EN enables the Match checks.
// ---------------------------------------------------------------------------
module tb_inv_key_schedule;

   logic         Clk = 1'b0;
   logic         Rst;
   logic         En;
   logic [127:0] LastKey;
   logic [3:0]   SelKey;
   logic [127:0] Key;
   logic         Ry;
`ifdef INV_KS_ORIG_CHECK_EN
   logic         Match;
`endif

   int n_vec = 0;
   int n_err = 0;

   logic [7:0]   sbox_m [0:255];
   logic [127:0] rk_m   [0:10];

   localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] FIPS_K9  = 128'hac7766f319fadc2128d12941575c006e;
   localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] FIPS_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   always #5 Clk = ~Clk;

   inv_key_schedule dut (
      .Clk     (Clk),
      .Rst     (Rst),
      .En      (En),
      .LastKey (LastKey),
      .SelKey  (SelKey),
      .Key     (Key),
      .Ry      (Ry)
`ifdef INV_KS_ORIG_CHECK_EN
     ,.Match   (Match)
`endif
   );

   // ---------------- reference model ----------------
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox_calc(input logic [7:0] a);
      logic [7:0] inv;
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gf_mul(inv, a);   // a^254 = a^-1, 0 -> 0
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
   endfunction

   task automatic build_model(input logic [127:0] k10);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rc;
      {w[40], w[41], w[42], w[43]} = k10;
      for (int i = 43; i >= 4; i--) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            rc = 8'h01;
            for (int j = 0; j < i/4 - 1; j++) rc = gf_mul(rc, 8'h02);
            t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
         end
         w[i-4] = w[i] ^ t;
      end
      for (int r = 0; r < 11; r++) rk_m[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   function automatic logic [127:0] rand_key();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Start on edge 0, then check Ry (and Match) after each of edges 0..10.
   // LastKey is scrambled after the start edge to show it is not resampled.
   task automatic run_expansion(input logic [127:0] k, input string tag);
      logic exp_ry;
      LastKey = k;
      En      = 1'b1;
      for (int e = 0; e <= 10; e++) begin
         tick();
         if (e == 0) begin
            En      = 1'b0;
            LastKey = rand_key();
         end
         exp_ry = (e == 10);
         n_vec++;
         if (Ry !== exp_ry) begin
            n_err++;
            $display("FAIL %s ry edge %0d: got %b expected %b", tag, e, Ry, exp_ry);
         end
`ifdef INV_KS_ORIG_CHECK_EN
         begin
            logic exp_m;
            exp_m = (e == 10) && (rk_m[0] == FIPS_K0);
            n_vec++;
            if (Match !== exp_m) begin
               n_err++;
               $display("FAIL %s match edge %0d: got %b expected %b", tag, e, Match, exp_m);
            end
         end
`endif
      end
   endtask

   task automatic read_all(input string tag);
      for (int s = 0; s < 11; s++) begin
         SelKey = 4'(s);
         tick();
         n_vec++;
         if (Key !== rk_m[s]) begin
            n_err++;
            $display("FAIL %s slot %0d: got %h expected %h", tag, s, Key, rk_m[s]);
         end
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      Rst = 1'b1; En = 1'b0; LastKey = '0; SelKey = 4'd0;
      tick();
      tick();
      Rst = 1'b0;
      n_vec++;
      if (Ry !== 1'b0 || Key !== 128'h0) begin
         n_err++;
         $display("FAIL reset: ry=%b key=%h expected 0/0", Ry, Key);
      end
`ifdef INV_KS_ORIG_CHECK_EN
      n_vec++;
      if (Match !== 1'b0) begin
         n_err++;
         $display("FAIL reset match: got %b expected 0", Match);
      end
`endif
      for (int s = 0; s < 16; s++) begin
         SelKey = 4'(s);
         tick();
         n_vec++;
         if (Key !== 128'h0) begin
            n_err++;
            $display("FAIL reset slot %0d: got %h expected 0", s, Key);
         end
      end
   endtask

   task automatic test_fips();
      build_model(FIPS_K10);
      run_expansion(FIPS_K10, "fips");
      read_all("fips");
      SelKey = 4'd0;  tick(); n_vec++;
      if (Key !== FIPS_K0) begin n_err++; $display("FAIL fips k0: got %h expected %h", Key, FIPS_K0); end
      SelKey = 4'd1;  tick(); n_vec++;
      if (Key !== FIPS_K1) begin n_err++; $display("FAIL fips k1: got %h expected %h", Key, FIPS_K1); end
      SelKey = 4'd9;  tick(); n_vec++;
      if (Key !== FIPS_K9) begin n_err++; $display("FAIL fips k9: got %h expected %h", Key, FIPS_K9); end
      SelKey = 4'd10; tick(); n_vec++;
      if (Key !== FIPS_K10) begin n_err++; $display("FAIL fips k10: got %h expected %h", Key, FIPS_K10); end
   endtask

   task automatic test_out_of_range();
      for (int s = 11; s < 16; s++) begin
         SelKey = 4'(s);
         tick();
         n_vec++;
         if (Key !== FIPS_K0) begin
            n_err++;
            $display("FAIL oor sel %0d: got %h expected %h", s, Key, FIPS_K0);
         end
      end
      n_vec++;
      if (Ry !== 1'b1) begin
         n_err++;
         $display("FAIL oor ry hold: got %b expected 1", Ry);
      end
`ifdef INV_KS_ORIG_CHECK_EN
      n_vec++;
      if (Match !== 1'b1) begin
         n_err++;
         $display("FAIL match hold: got %b expected 1", Match);
      end
`endif
   endtask

   task automatic test_abort();
      logic [127:0] k;
      LastKey = rand_key();
      En      = 1'b1;
      tick();                       // edge 0
      En = 1'b0;
      for (int e = 1; e <= 4; e++) tick();
      Rst = 1'b1;
      tick();                       // edge 5
      Rst = 1'b0;
      n_vec++;
      if (Ry !== 1'b0 || Key !== 128'h0) begin
         n_err++;
         $display("FAIL abort: ry=%b key=%h expected 0/0", Ry, Key);
      end
      for (int s = 0; s < 16; s++) begin
         SelKey = 4'(s);
         tick();
         n_vec++;
         if (Key !== 128'h0 || Ry !== 1'b0) begin
            n_err++;
            $display("FAIL abort sel %0d: key=%h ry=%b expected 0/0", s, Key, Ry);
         end
      end
      k = rand_key();
      build_model(k);
      run_expansion(k, "after_abort");
      read_all("after_abort");
   endtask

   task automatic test_busy_start();
      logic [127:0] ka, kb;
      logic         exp_ry;
      ka = rand_key();
      kb = rand_key();
      build_model(ka);
      LastKey = ka;
      En      = 1'b1;
      for (int e = 0; e <= 11; e++) begin
         tick();
         if (e == 2)  LastKey = kb;          // present at edge 3
         if (e == 10) SelKey  = 4'd0;        // read slot0 on edge 11
         exp_ry = (e == 10);
         n_vec++;
         if (Ry !== exp_ry) begin
            n_err++;
            $display("FAIL busy ry edge %0d: got %b expected %b", e, Ry, exp_ry);
         end
      end
      n_vec++;
      if (Key !== rk_m[0]) begin
         n_err++;
         $display("FAIL busy first slot0: got %h expected %h", Key, rk_m[0]);
      end
      En     = 1'b0;
      SelKey = 4'd9;
      tick();                               // edge 12: old slot9 still visible
      n_vec++;
      if (Key !== rk_m[9]) begin
         n_err++;
         $display("FAIL busy first slot9: got %h expected %h", Key, rk_m[9]);
      end
      build_model(kb);
      for (int e = 13; e <= 21; e++) begin
         tick();
         exp_ry = (e == 21);
         n_vec++;
         if (Ry !== exp_ry) begin
            n_err++;
            $display("FAIL busy restart ry edge %0d: got %b expected %b", e, Ry, exp_ry);
         end
      end
      read_all("busy_restart");
   endtask

   task automatic test_zero_key();
      build_model(128'h0);
      run_expansion(128'h0, "zero");
      read_all("zero");
   endtask

   task automatic test_random();
      logic [127:0] k;
      for (int n = 0; n < 4; n++) begin
         k = rand_key();
         build_model(k);
         run_expansion(k, "random");
         read_all("random");
      end
   endtask

`ifdef INV_KS_ORIG_CHECK_EN
   task automatic test_match_flip();
      build_model(FIPS_K10 ^ 128'h1);
      run_expansion(FIPS_K10 ^ 128'h1, "flip");
      n_vec++;
      if (Match !== 1'b0) begin
         n_err++;
         $display("FAIL flip match: got %b expected 0", Match);
      end
   endtask
`endif

   initial begin
      for (int i = 0; i < 256; i++) sbox_m[i] = sbox_calc(8'(i));
      Rst = 1'b1; En = 1'b0; LastKey = '0; SelKey = 4'd0;
      test_reset();
      test_fips();
      test_out_of_range();
      test_abort();
      test_busy_start();
      test_zero_key();
      test_random();
`ifdef INV_KS_ORIG_CHECK_EN
      test_match_flip();
      test_fips();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_inv_key_schedule
